// File: rtl/okim6295_banked_if.sv
// Bus bundle around the banked OKI ADPCM wrapper: CPU, bank, ROM, audio and core-side signals.
// Latency: none, this is wiring only.
// Backpressure: the ROM side is request/acknowledge (io_rom_rd held until io_rom_valid); the rest is strobed.
// Ports: slave = wrapper view, master = environment view (CPU, ROM arbiter, mixer, jt6295 core).
interface okim6295_banked_if #(
    parameter int BANK_WIDTH  = 4,
    parameter int AUDIO_WIDTH = 16
);
    // sound CPU bus
    logic                        io_cpu_wr;
    logic [7:0]                  io_cpu_din;
    logic [7:0]                  io_cpu_dout;
    // bank registers
    logic                        io_bank_wr;
    logic [1:0]                  io_bank_addr;
    logic [BANK_WIDTH-1:0]       io_bank_din;
    // ROM arbiter
    logic                        io_rom_rd;
    logic [16+BANK_WIDTH-1:0]    io_rom_addr;
    logic [7:0]                  io_rom_dout;
    logic                        io_rom_valid;
    // audio mixer
    logic                        io_audio_valid;
    logic [AUDIO_WIDTH-1:0]      io_audio_bits;
    // jt6295 core connection
    logic                        core_rst;
    logic                        core_cen;
    logic                        core_ss;
    logic                        core_wrn;
    logic [7:0]                  core_din;
    logic [7:0]                  core_dout;
    logic [17:0]                 core_addr;
    logic [7:0]                  core_rom_data;
    logic                        core_rom_ok;
    logic signed [13:0]          core_sound;
    logic                        core_sample;

    modport slave (
        input  io_cpu_wr, io_cpu_din, io_bank_wr, io_bank_addr, io_bank_din,
        input  io_rom_dout, io_rom_valid,
        input  core_dout, core_addr, core_sound, core_sample,
        output io_cpu_dout, io_rom_rd, io_rom_addr, io_audio_valid, io_audio_bits,
        output core_rst, core_cen, core_ss, core_wrn, core_din, core_rom_data, core_rom_ok
    );

    modport master (
        output io_cpu_wr, io_cpu_din, io_bank_wr, io_bank_addr, io_bank_din,
        output io_rom_dout, io_rom_valid,
        output core_dout, core_addr, core_sound, core_sample,
        input  io_cpu_dout, io_rom_rd, io_rom_addr, io_audio_valid, io_audio_bits,
        input  core_rst, core_cen, core_ss, core_wrn, core_din, core_rom_data, core_rom_ok
    );
endinterface

// File: rtl/okim6295_banked.sv
// Banked OKI ADPCM wrapper: fractional clock enable, NMK112-style ROM banking, ROM fetch FSM, gain/saturation.
// Latency: ROM address follows the core address by 1 cycle; audio sample is registered 1 cycle after core sample.
// Backpressure: io_rom_rd is held until io_rom_valid arrives for the current address; audio has none.
// Ports: clock, reset (async active-low), bus (slave modport of okim6295_banked_if).
module okim6295_banked #(
    parameter int                   CEN_WIDTH      = 16,
    parameter logic [CEN_WIDTH-1:0] CEN_INC        = 16'h10E5,
    parameter int                   BANK_WIDTH     = 4,
    parameter int                   PHRASE_BANKING = 1,
    parameter int                   AUDIO_WIDTH    = 16,
    parameter int                   GAIN_SHIFT     = 2
) (
    input  logic               clock,
    input  logic               reset,
    okim6295_banked_if.slave   bus
);
    localparam int EXT = AUDIO_WIDTH + GAIN_SHIFT;
    localparam int AW  = 16 + BANK_WIDTH;

    typedef enum logic {IDLE, REQ} state_t;

    // Release of reset is resynchronised; assertion stays asynchronous.
    logic rst_s1_q, rst_s2_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_s1_q <= 1'b0;
            rst_s2_q <= 1'b0;
        end else begin
            rst_s1_q <= 1'b1;
            rst_s2_q <= rst_s1_q;
        end
    end

    // Fractional clock enable: carry out of the phase accumulator.
    logic [CEN_WIDTH-1:0] acc_q;
    logic                 cen_q;
    logic [CEN_WIDTH:0]   acc_sum;
    assign acc_sum = {1'b0, acc_q} + {1'b0, CEN_INC};

    always_ff @(posedge clock or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            acc_q <= '0;
            cen_q <= 1'b0;
        end else begin
            acc_q <= acc_sum[CEN_WIDTH-1:0];
            cen_q <= acc_sum[CEN_WIDTH];
        end
    end

    // Bank registers.
    logic [BANK_WIDTH-1:0] banks_q [4];
    always_ff @(posedge clock or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            for (int i = 0; i < 4; i++) banks_q[i] <= '0;
        end else if (bus.io_bank_wr) begin
            banks_q[bus.io_bank_addr] <= bus.io_bank_din;
        end
    end

    // Address mapping: the phrase table (below 0x400) is banked by A[9:8].
    logic [1:0]    page;
    logic [AW-1:0] mapped;
    always_comb begin
        page = bus.core_addr[17:16];
        if (PHRASE_BANKING != 0 && bus.core_addr < 18'h400) page = bus.core_addr[9:8];
        mapped = {banks_q[page], bus.core_addr[15:0]};
    end

    // ROM fetch FSM.
    state_t        state_q, state_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          rom_rd_q, rom_rd_d;
    logic          rom_ok_q, rom_ok_d;
    logic [7:0]    rom_data_q, rom_data_d;

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_rd_d   = rom_rd_q;
        rom_ok_d   = rom_ok_q;
        rom_data_d = rom_data_q;
        case (state_q)
            IDLE: begin
                if (mapped != rom_addr_q) begin
                    rom_addr_d = mapped;
                    rom_ok_d   = 1'b0;
                    rom_rd_d   = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A moving address restarts the fetch; an acknowledge in that
                // same cycle belongs to the old address and is dropped.
                if (mapped != rom_addr_q) begin
                    rom_addr_d = mapped;
                end else if (bus.io_rom_valid) begin
                    rom_data_d = bus.io_rom_dout;
                    rom_rd_d   = 1'b0;
                    rom_ok_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            rom_ok_q   <= 1'b0;
            rom_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_rd_q   <= rom_rd_d;
            rom_ok_q   <= rom_ok_d;
            rom_data_q <= rom_data_d;
        end
    end

    // Audio gain and saturation: overflow when the bits above the output
    // sign bit disagree with it.
    logic signed [EXT-1:0]       ext_sound, scaled;
    logic [GAIN_SHIFT:0]         top;
    logic [AUDIO_WIDTH-1:0]      audio_d;
    always_comb begin
        ext_sound = EXT'(bus.core_sound);
        scaled    = ext_sound <<< GAIN_SHIFT;
        top       = scaled[EXT-1:AUDIO_WIDTH-1];
        if (&top || ~|top)  audio_d = scaled[AUDIO_WIDTH-1:0];
        else if (top[GAIN_SHIFT]) audio_d = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
        else                audio_d = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};
    end

    logic                   audio_valid_q;
    logic [AUDIO_WIDTH-1:0] audio_bits_q;
    always_ff @(posedge clock or negedge rst_s2_q) begin
        if (!rst_s2_q) begin
            audio_valid_q <= 1'b0;
            audio_bits_q  <= '0;
        end else begin
            audio_valid_q <= bus.core_sample;
            if (bus.core_sample) audio_bits_q <= audio_d;
        end
    end

    assign bus.core_rst       = ~reset;
    assign bus.core_cen       = cen_q;
    assign bus.core_ss        = 1'b1;
    assign bus.core_wrn       = ~bus.io_cpu_wr;
    assign bus.core_din       = bus.io_cpu_din;
    assign bus.io_cpu_dout    = bus.core_dout;
    assign bus.core_rom_data  = rom_data_q;
    assign bus.core_rom_ok    = rom_ok_q;
    assign bus.io_rom_rd      = rom_rd_q;
    assign bus.io_rom_addr    = rom_addr_q;
    assign bus.io_audio_valid = audio_valid_q;
    assign bus.io_audio_bits  = audio_bits_q;
endmodule

// File: doc/okim6295_banked.md
Name: okim6295_banked

Overview:
Parametrised successor to the single-configuration OKI ADPCM wrapper. It drives a jt6295 core and adds:
- a programmable fractional clock-enable;
- NMK112-style ROM bank switching, including phrase-table banking;
- a registered ROM request/acknowledge handshake;
- a width-generalised, gain-scaled, saturating audio output.

It sits between the sound CPU bus, the sound ROM arbiter and the audio mixer.

Parameters:
CEN_WIDTH, 16, clock-enable phase accumulator width.
CEN_INC, 16'h10E5, accumulator increment; f_cen = f_clk*CEN_INC/2^CEN_WIDTH (1.056 MHz at 16 MHz).
BANK_WIDTH, 4, bits per bank register; io_rom_addr width = 16+BANK_WIDTH.
PHRASE_BANKING, 1, 1 = addresses below 0x400 are banked by A[9:8] instead of A[17:16].
AUDIO_WIDTH, 16, output sample width (must be >= 14).
GAIN_SHIFT, 2, left shift applied to the core sample before saturation.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
io_cpu_wr  in  1  write strobe to the ADPCM core (one cycle)
io_cpu_din  in  8  write data to the core
io_cpu_dout  out  8  core status byte
io_bank_wr  in  1  bank register write strobe
io_bank_addr  in  2  bank register index
io_bank_din  in  BANK_WIDTH  bank value
io_rom_rd  out  1  ROM request, level, held until acknowledged
io_rom_addr  out  16+BANK_WIDTH  mapped ROM byte address
io_rom_dout  in  8  ROM data
io_rom_valid  in  1  ROM acknowledge; data qualified in this cycle
io_audio_valid  out  1  one-cycle pulse per output sample
io_audio_bits  out  AUDIO_WIDTH  signed sample

Behaviour:
Reset:
- While reset=0, all registers clear: accumulator, cen, banks[0..3], FSM=IDLE, io_rom_rd=0, io_rom_addr=0, data latch=0, rom_ok=0, io_audio_valid=0, io_audio_bits=0.
- Core rst = ~reset.
- Deassertion is synchronised by a 2-flop synchroniser before releasing internal state.

Clock enable:
- Each clock: acc <= acc + CEN_INC (CEN_WIDTH bits, wraps); cen <= carry out.
- cen is high for exactly one cycle per carry.

Bank registers:
- On io_bank_wr: banks[io_bank_addr] <= io_bank_din.
- A write takes effect on the mapping in the next cycle.

Address mapping (combinational from the core address A[17:0]):
- page = A[17:16], except when PHRASE_BANKING=1 and A<0x400, where page = A[9:8].
- mapped = {banks[page], A[15:0]}.

ROM FSM (IDLE, REQ):
- IDLE: if mapped != io_rom_addr, then io_rom_addr <= mapped, rom_ok <= 0, io_rom_rd <= 1, go to REQ. Otherwise hold, with rom_ok=1 once any fetch has completed.
- REQ, mapped == io_rom_addr and io_rom_valid=1: latch io_rom_dout, io_rom_rd <= 0, rom_ok <= 1, go to IDLE.
- REQ, mapped != io_rom_addr: io_rom_addr <= mapped and stay in REQ. io_rom_valid in that same cycle is ignored (stale data). io_rom_rd stays high.
- io_rom_valid is ignored in IDLE.
- Core rom_data is the latch; core rom_ok is the registered rom_ok.
- A bank write that changes mapped restarts a fetch through the same rule.

Audio:
- On core sample=1, the 14-bit signed sound is sign-extended to AUDIO_WIDTH+GAIN_SHIFT, shifted left by GAIN_SHIFT, then saturated to AUDIO_WIDTH. Saturation limits are +2^(AUDIO_WIDTH-1)-1 and -2^(AUDIO_WIDTH-1).
- The result is registered to io_audio_bits and io_audio_valid pulses in the next cycle (latency 1).
- io_audio_bits holds its value between pulses.

CPU path:
- Core wrn = ~io_cpu_wr; ss tied 1; io_cpu_dout = core dout.
- Simultaneous io_cpu_wr and io_bank_wr are independent and both take effect.

Test Plan:
1. Clock-enable cadence: defaults, run 65536 cycles -> exactly 4325 cen pulses, none adjacent.
2. Bank mapping: banks = {1,2,3,4}; core addr 0x2_1234 -> io_rom_addr 0x3_1234. With PHRASE_BANKING=1, addr 0x0_0210 -> 0x3_0210. With PHRASE_BANKING=0, addr 0x0_0210 -> 0x1_0210.
3. Handshake: io_rom_valid delayed 5 cycles after io_rom_rd -> io_rom_rd stays high 5 cycles; rom_ok rises the cycle after valid; latched data matches.
4. Address change mid-request: new mapped address on cycle 2 of REQ, with valid asserted that cycle -> valid ignored, io_rom_addr updates, io_rom_rd remains 1, the subsequent valid completes the fetch.
5. Saturation, with GAIN_SHIFT=2 and AUDIO_WIDTH=16:
   - core sound 0x1FFF -> 0x7FFC
   - with GAIN_SHIFT=3, 0x1FFF -> 0x7FFF and 0x2000 (-8192) -> 0x8000
   - io_audio_valid is a single-cycle pulse one cycle after core sample.
6. Reset mid-request: assert reset low during REQ -> io_rom_rd, io_rom_addr, banks and audio outputs are all 0 immediately (asynchronously); after release, the first fetch starts from IDLE.
